// File: rtl/frontend_pkg.sv
// Shared front-end types and constants for the fetch/decode boundary.
// Holds instruction width, default PC width and buffer depth, and the fetch-mask bit positions.
package frontend_pkg;

  localparam int INST_W         = 32;
  localparam int PC_W           = 64;
  localparam int INST_BUF_DEPTH = 8;

  localparam int FETCH_LO_BIT = 0;
  localparam int FETCH_HI_BIT = 1;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } ibuf_entry_t;

  // Number of instructions a fetch mask carries (0, 1 or 2).
  function automatic logic [1:0] mask_inst_cnt(input logic [1:0] mask);
    return {1'b0, mask[FETCH_LO_BIT]} + {1'b0, mask[FETCH_HI_BIT]};
  endfunction

endpackage

// File: rtl/inst_buffer_mem.sv
// Instruction entry storage: DEPTH x W register array.
// Two write ports and one combinational read port; contents are not reset.
module inst_buffer_mem #(
  parameter  int DEPTH = 8,
  parameter  int W     = 96,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr0_en,
  input  logic [AW-1:0] wr0_idx,
  input  logic [W-1:0]  wr0_data,
  input  logic          wr1_en,
  input  logic [AW-1:0] wr1_idx,
  input  logic [W-1:0]  wr1_data,
  input  logic [AW-1:0] rd_idx,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  // The two write indices are always distinct (consecutive slots of one line).
  always_ff @(posedge clk) begin
    if (wr0_en) mem[wr0_idx] <= wr0_data;
    if (wr1_en) mem[wr1_idx] <= wr1_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/inst_buffer.sv
// Instruction buffer: splits 64-bit fetch lines into 32-bit entries, FWFT head to the decoder.
// Optional INST_BUF_PERF_EN adds stall/empty performance counters.
module inst_buffer #(
  parameter  int DEPTH = frontend_pkg::INST_BUF_DEPTH,
  parameter  int PC_W  = frontend_pkg::PC_W,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
`ifdef INST_BUF_PERF_EN
  output logic [31:0]     stall_cnt,
  output logic [31:0]     empty_cnt,
`endif
  input  logic            fetch_valid,
  output logic            fetch_ready,
  input  logic [63:0]     fetch_line,
  input  logic [PC_W-1:0] fetch_pc,
  input  logic [1:0]      fetch_mask,
  input  logic            fifo_rd_en,
  output logic            fifo_empty,
  output logic [31:0]     fifo_data_out,
  output logic [PC_W-1:0] fifo_pc,
  output logic [CW-1:0]   fifo_count
);

  import frontend_pkg::*;

  localparam int AW      = $clog2(DEPTH);
  localparam int ENTRY_W = INST_W + PC_W;

  logic [CW-1:0] wptr, rptr, count;
  logic [CW-1:0] wptr_p1;
  logic [CW:0]   count_sum;
  logic          push, pop;
  logic [1:0]    n_push;

  logic [ENTRY_W-1:0] lo_ent, hi_ent;
  logic               wr0_en, wr1_en;
  logic [ENTRY_W-1:0] wr0_data;
  logic [ENTRY_W-1:0] rd_data;

  // Room check uses only the registered count, so a same-cycle pop never opens space.
  assign fetch_ready = !flush && (count <= CW'(DEPTH - 2));
  assign push        = fetch_valid && fetch_ready;
  assign pop         = fifo_rd_en && !fifo_empty;
  assign n_push      = push ? mask_inst_cnt(fetch_mask) : 2'd0;
  assign count_sum   = {1'b0, count} + (CW+1)'(n_push) - (CW+1)'(pop);

  assign lo_ent  = {fetch_line[31:0],  fetch_pc};
  assign hi_ent  = {fetch_line[63:32], fetch_pc + PC_W'(4)};
  assign wptr_p1 = wptr + CW'(1);

  // Port 0 takes the oldest valid instruction of the line; port 1 only the upper one of a pair.
  assign wr0_en   = push && (fetch_mask != 2'b00);
  assign wr1_en   = push && (fetch_mask == 2'b11);
  assign wr0_data = fetch_mask[FETCH_LO_BIT] ? lo_ent : hi_ent;

  inst_buffer_mem #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_mem (
    .clk      (clk),
    .wr0_en   (wr0_en),
    .wr0_idx  (wptr[AW-1:0]),
    .wr0_data (wr0_data),
    .wr1_en   (wr1_en),
    .wr1_idx  (wptr_p1[AW-1:0]),
    .wr1_data (hi_ent),
    .rd_idx   (rptr[AW-1:0]),
    .rd_data  (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + CW'(n_push);
      rptr  <= rptr + CW'(pop);
      count <= count_sum[CW-1:0];
    end
  end

  assign fifo_empty    = (count == '0);
  assign fifo_count    = count;
  assign fifo_data_out = fifo_empty ? '0 : rd_data[ENTRY_W-1 -: INST_W];
  assign fifo_pc       = fifo_empty ? '0 : rd_data[PC_W-1:0];

`ifdef INST_BUF_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      empty_cnt <= '0;
    end else begin
      if (fetch_valid && !fetch_ready && !flush && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
      if (fifo_empty && (empty_cnt != 32'hFFFF_FFFF))
        empty_cnt <= empty_cnt + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  // A wrapped (underflowed) sum also shows up as a value above DEPTH.
  a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
    count_sum <= (CW+1)'(DEPTH))
    else $error("inst_buffer occupancy out of range: %0d", count_sum);
`endif

endmodule

// File: tb/tb_inst_buffer.sv
// Directed, table-driven bench for inst_buffer (DEPTH=8, PC_W=64).
module tb_inst_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        fetch_valid = 1'b0;
  logic        fetch_ready;
  logic [63:0] fetch_line = '0;
  logic [63:0] fetch_pc = '0;
  logic [1:0]  fetch_mask = '0;
  logic        fifo_rd_en = 1'b0;
  logic        fifo_empty;
  logic [31:0] fifo_data_out;
  logic [63:0] fifo_pc;
  logic [3:0]  fifo_count;
`ifdef INST_BUF_PERF_EN
  logic [31:0] stall_cnt, empty_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_buffer #(.DEPTH(8), .PC_W(64)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
`ifdef INST_BUF_PERF_EN
    .stall_cnt     (stall_cnt),
    .empty_cnt     (empty_cnt),
`endif
    .fetch_valid   (fetch_valid),
    .fetch_ready   (fetch_ready),
    .fetch_line    (fetch_line),
    .fetch_pc      (fetch_pc),
    .fetch_mask    (fetch_mask),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_empty    (fifo_empty),
    .fifo_data_out (fifo_data_out),
    .fifo_pc       (fifo_pc),
    .fifo_count    (fifo_count)
  );

  typedef struct {
    logic        rd, vld, fl;
    logic [1:0]  mask;
    logic [63:0] line, pc;
    logic        e_empty;
    logic [31:0] e_data;
    logic [63:0] e_pc;
    logic [3:0]  e_count;
    logic        e_ready;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rd, logic vld, logic fl, logic [1:0] mask,
                              logic [63:0] line, logic [63:0] pc, logic ee,
                              logic [31:0] ed, logic [63:0] ep, logic [3:0] ec, logic er);
    vec_t v;
    v.rd = rd; v.vld = vld; v.fl = fl; v.mask = mask; v.line = line; v.pc = pc;
    v.e_empty = ee; v.e_data = ed; v.e_pc = ep; v.e_count = ec; v.e_ready = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic ee, input logic [31:0] ed,
                             input logic [63:0] ep, input logic [3:0] ec, input logic er);
    chk({tag, ".empty"}, 64'(fifo_empty),    64'(ee));
    chk({tag, ".data"},  64'(fifo_data_out), 64'(ed));
    chk({tag, ".pc"},    fifo_pc,            ep);
    chk({tag, ".count"}, 64'(fifo_count),    64'(ec));
    chk({tag, ".ready"}, 64'(fetch_ready),   64'(er));
  endtask

  task automatic drive(input logic rd, input logic vld, input logic fl, input logic [1:0] mask,
                       input logic [63:0] line, input logic [63:0] pc);
    fifo_rd_en = rd; fetch_valid = vld; flush = fl;
    fetch_mask = mask; fetch_line = line; fetch_pc = pc;
  endtask

  initial begin
    // Basic split: pair, then upper-only line
    vecs.push_back(mk(0,1,0,2'b11,64'h00500093_00100113,64'h8000_0000, 1,32'h0,64'h0,0,1));
    vecs.push_back(mk(0,0,0,2'b00,64'h0,64'h0, 0,32'h00100113,64'h8000_0000,2,1));
    vecs.push_back(mk(1,0,0,2'b00,64'h0,64'h0, 0,32'h00100113,64'h8000_0000,2,1));
    vecs.push_back(mk(1,0,0,2'b00,64'h0,64'h0, 0,32'h00500093,64'h8000_0004,1,1));
    vecs.push_back(mk(0,0,0,2'b00,64'h0,64'h0, 1,32'h0,64'h0,0,1));
    vecs.push_back(mk(0,1,0,2'b10,64'hAAAA0001_BBBB0002,64'h8000_0008, 1,32'h0,64'h0,0,1));
    vecs.push_back(mk(0,0,0,2'b00,64'h0,64'h0, 0,32'hAAAA0001,64'h8000_000C,1,1));
    vecs.push_back(mk(1,0,0,2'b00,64'h0,64'h0, 0,32'hAAAA0001,64'h8000_000C,1,1));
    // Fill to 8, hold fifth line until two slots free, then drain in order
    vecs.push_back(mk(0,1,0,2'b11,64'h11110001_11110000,64'h100, 1,32'h0,64'h0,0,1));
    vecs.push_back(mk(0,1,0,2'b11,64'h22220001_22220000,64'h108, 0,32'h11110000,64'h100,2,1));
    vecs.push_back(mk(0,1,0,2'b11,64'h33330001_33330000,64'h110, 0,32'h11110000,64'h100,4,1));
    vecs.push_back(mk(0,1,0,2'b11,64'h44440001_44440000,64'h118, 0,32'h11110000,64'h100,6,1));
    vecs.push_back(mk(0,1,0,2'b11,64'h55550001_55550000,64'h120, 0,32'h11110000,64'h100,8,0));
    vecs.push_back(mk(1,1,0,2'b11,64'h55550001_55550000,64'h120, 0,32'h11110000,64'h100,8,0));
    vecs.push_back(mk(1,1,0,2'b11,64'h55550001_55550000,64'h120, 0,32'h11110001,64'h104,7,0));
    vecs.push_back(mk(0,1,0,2'b11,64'h55550001_55550000,64'h120, 0,32'h22220000,64'h108,6,1));
    vecs.push_back(mk(1,0,0,2'b00,64'h0,64'h0, 0,32'h22220000,64'h108,8,0));
    vecs.push_back(mk(1,0,0,2'b00,64'h0,64'h0, 0,32'h22220001,64'h10C,7,0));
    vecs.push_back(mk(1,0,0,2'b00,64'h0,64'h0, 0,32'h33330000,64'h110,6,1));
    vecs.push_back(mk(1,0,0,2'b00,64'h0,64'h0, 0,32'h33330001,64'h114,5,1));
    vecs.push_back(mk(1,0,0,2'b00,64'h0,64'h0, 0,32'h44440000,64'h118,4,1));
    vecs.push_back(mk(1,0,0,2'b00,64'h0,64'h0, 0,32'h44440001,64'h11C,3,1));
    vecs.push_back(mk(1,0,0,2'b00,64'h0,64'h0, 0,32'h55550000,64'h120,2,1));
    vecs.push_back(mk(1,0,0,2'b00,64'h0,64'h0, 0,32'h55550001,64'h124,1,1));
    vecs.push_back(mk(0,0,0,2'b00,64'h0,64'h0, 1,32'h0,64'h0,0,1));
    // Lower-only push, simultaneous push+pop at count 3, pop-while-empty, mask 00
    vecs.push_back(mk(0,1,0,2'b11,64'hA0000001_A0000000,64'h200, 1,32'h0,64'h0,0,1));
    vecs.push_back(mk(0,1,0,2'b01,64'hDEADBEEF_B0000000,64'h208, 0,32'hA0000000,64'h200,2,1));
    vecs.push_back(mk(1,1,0,2'b11,64'hC0000001_C0000000,64'h210, 0,32'hA0000000,64'h200,3,1));
    vecs.push_back(mk(0,0,0,2'b00,64'h0,64'h0, 0,32'hA0000001,64'h204,4,1));
    vecs.push_back(mk(1,0,0,2'b00,64'h0,64'h0, 0,32'hA0000001,64'h204,4,1));
    vecs.push_back(mk(1,0,0,2'b00,64'h0,64'h0, 0,32'hB0000000,64'h208,3,1));
    vecs.push_back(mk(1,0,0,2'b00,64'h0,64'h0, 0,32'hC0000000,64'h210,2,1));
    vecs.push_back(mk(1,0,0,2'b00,64'h0,64'h0, 0,32'hC0000001,64'h214,1,1));
    vecs.push_back(mk(1,0,0,2'b00,64'h0,64'h0, 1,32'h0,64'h0,0,1));
    vecs.push_back(mk(0,0,0,2'b00,64'h0,64'h0, 1,32'h0,64'h0,0,1));
    vecs.push_back(mk(0,1,0,2'b00,64'h66666666_66666666,64'h300, 1,32'h0,64'h0,0,1));
    vecs.push_back(mk(0,0,0,2'b00,64'h0,64'h0, 1,32'h0,64'h0,0,1));
    // Flush at count 6 together with push and pop
    vecs.push_back(mk(0,1,0,2'b11,64'hD0000001_D0000000,64'h400, 1,32'h0,64'h0,0,1));
    vecs.push_back(mk(0,1,0,2'b11,64'hE0000001_E0000000,64'h408, 0,32'hD0000000,64'h400,2,1));
    vecs.push_back(mk(0,1,0,2'b11,64'hF0000001_F0000000,64'h410, 0,32'hD0000000,64'h400,4,1));
    vecs.push_back(mk(1,1,1,2'b11,64'h77777777_77777777,64'h418, 0,32'hD0000000,64'h400,6,0));
    vecs.push_back(mk(0,0,0,2'b00,64'h0,64'h0, 1,32'h0,64'h0,0,1));
    vecs.push_back(mk(0,1,0,2'b11,64'h12340001_12340000,64'h500, 1,32'h0,64'h0,0,1));
    vecs.push_back(mk(0,0,0,2'b00,64'h0,64'h0, 0,32'h12340000,64'h500,2,1));

    // Reset state while rst_n is held low
    #12;
    chk_outputs("reset", 1'b1, 32'h0, 64'h0, 4'd0, 1'b1);
`ifdef INST_BUF_PERF_EN
    chk("reset.stall_cnt", 64'(stall_cnt), 64'h0);
    chk("reset.empty_cnt", 64'(empty_cnt), 64'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rd, vecs[i].vld, vecs[i].fl, vecs[i].mask, vecs[i].line, vecs[i].pc);
      #1;
      chk_outputs($sformatf("vec%0d", i), vecs[i].e_empty, vecs[i].e_data,
                  vecs[i].e_pc, vecs[i].e_count, vecs[i].e_ready);
    end

    // Bring occupancy to 5, then assert reset asynchronously mid-cycle
    @(negedge clk);
    drive(0, 1, 0, 2'b11, 64'h99990001_99990000, 64'h600);
    @(negedge clk);
    drive(0, 1, 0, 2'b01, 64'h0BAD0BAD_88880000, 64'h608);
    @(negedge clk);
    drive(0, 0, 0, 2'b00, 64'h0, 64'h0);
    #1;
    chk("pre_rst.count", 64'(fifo_count), 64'd5);
    #1;
    rst_n = 1'b0;
    #1;
    chk_outputs("async_rst", 1'b1, 32'h0, 64'h0, 4'd0, 1'b1);
`ifdef INST_BUF_PERF_EN
    chk("async_rst.stall_cnt", 64'(stall_cnt), 64'h0);
    chk("async_rst.empty_cnt", 64'(empty_cnt), 64'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk_outputs("post_rst", 1'b1, 32'h0, 64'h0, 4'd0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
